// File: rtl/pwm_capture_if.sv
// Port bundle for pwm_capture. The DUT connects through the slave modport;
// a driver or a bench uses the master modport.
interface pwm_capture_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 enable;
  logic                 pwmInput;
  logic                 clearOverflow;
  logic [CNT_WIDTH-1:0] highTime;
  logic [CNT_WIDTH-1:0] period;
  logic                 valid;
  logic                 overflow;

  modport master (
    output enable,
    output pwmInput,
    output clearOverflow,
    input  highTime,
    input  period,
    input  valid,
    input  overflow
  );

  modport slave (
    input  enable,
    input  pwmInput,
    input  clearOverflow,
    output highTime,
    output period,
    output valid,
    output overflow
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures the high time and the rise-to-rise period of an
// asynchronous PWM input, in clk cycles, with a sticky saturation flag.
module pwm_capture #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d_q;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   hi_cap_q, hi_cap_d;
  logic [CNT_WIDTH-1:0]   high_time_q, high_time_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   overflow_q, overflow_d;

  logic s;
  logic rise;
  logic fall;
  logic cnt_sat;

  // Synchronizer input stage: shift the raw input in at bit 0
  generate
    if (SYNC_STAGES > 1) begin : g_sync_shift
      assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.pwmInput};
    end else begin : g_sync_single
      assign sync_d = bus.pwmInput;
    end
  endgenerate

  // Edge detect on the synchronized level; rises and falls see equal latency
  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d_q;
  assign fall    = ~s & s_d_q;
  assign cnt_sat = (cnt_q == CNT_MAX);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_cap_d    = hi_cap_q;
    high_time_d = high_time_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    overflow_d  = overflow_q & ~bus.clearOverflow;

    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = CNT_ZERO;
          state_d = WAIT_RISE;
        end

        WAIT_RISE: begin
          cnt_d = CNT_ZERO;
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = MEAS_HIGH;
          end
        end

        MEAS_HIGH: begin
          if (fall) begin
            hi_cap_d = cnt_q;
            cnt_d    = cnt_q + CNT_ONE;
            state_d  = MEAS_LOW;
          end else if (cnt_sat) begin
            overflow_d = 1'b1;
            cnt_d      = CNT_ZERO;
            state_d    = WAIT_RISE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        MEAS_LOW: begin
          // The terminating rise of one period is the starting rise of the next
          if (rise) begin
            high_time_d = hi_cap_q;
            period_d    = cnt_q;
            valid_d     = 1'b1;
            cnt_d       = CNT_ONE;
            state_d     = MEAS_HIGH;
          end else if (cnt_sat) begin
            overflow_d = 1'b1;
            cnt_d      = CNT_ZERO;
            state_d    = WAIT_RISE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Register stage: synchronizer, FSM, counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      s_d_q       <= 1'b0;
      cnt_q       <= CNT_ZERO;
      hi_cap_q    <= CNT_ZERO;
      high_time_q <= CNT_ZERO;
      period_q    <= CNT_ZERO;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      s_d_q       <= s;
      cnt_q       <= cnt_d;
      hi_cap_q    <= hi_cap_d;
      high_time_q <= high_time_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.highTime = high_time_q;
  assign bus.period   = period_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 16-bit instance measures PWM streams
// against a scoreboard, an 8-bit instance exercises saturation and overflow.
module tb_pwm_capture;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pwm_capture_if #(.CNT_WIDTH(16)) ifa ();
  pwm_capture_if #(.CNT_WIDTH(8))  ifb ();

  pwm_capture #(.CNT_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  pwm_capture #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] q_hi[$];
  logic [31:0] q_per[$];
  logic [31:0] exp_h, exp_p;
  int          armed;
  int          prev_h, prev_p;
  int          valid8_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One PWM period on the 16-bit instance; its rise completes the previous period
  task automatic pwm_period(input int h, input int l);
    if (armed != 0) begin
      q_hi.push_back(32'(prev_h));
      q_per.push_back(32'(prev_p));
    end
    prev_h = h;
    prev_p = h + l;
    armed  = 1;
    ifa.pwmInput = 1'b1;
    repeat (h) tick();
    ifa.pwmInput = 1'b0;
    repeat (l) tick();
  endtask

  always @(negedge clk) begin
    if (ifa.valid === 1'b1) begin
      if (q_hi.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_h = q_hi.pop_front();
        exp_p = q_per.pop_front();
        check("sb_highTime", 32'(ifa.highTime), exp_h);
        check("sb_period", 32'(ifa.period), exp_p);
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.valid === 1'b1) valid8_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    armed = 0;
    prev_h = 0;
    prev_p = 0;
    ifa.enable = 1'b0; ifa.pwmInput = 1'b0; ifa.clearOverflow = 1'b0;
    ifb.enable = 1'b0; ifb.pwmInput = 1'b0; ifb.clearOverflow = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_highTime", 32'(ifa.highTime), 32'd0);
    check("rst_period", 32'(ifa.period), 32'd0);
    check("rst_valid", 32'(ifa.valid), 32'd0);
    check("rst_overflow", 32'(ifa.overflow), 32'd0);

    // Steady 30/100, then duty change, then the minimum waveform
    ifa.enable = 1'b1;
    repeat (5) tick();
    repeat (4) pwm_period(30, 70);
    check("steady_overflow", 32'(ifa.overflow), 32'd0);
    repeat (3) pwm_period(75, 25);
    repeat (6) pwm_period(1, 1);
    check("toggle_overflow", 32'(ifa.overflow), 32'd0);
    repeat (3) pwm_period(30, 70);

    // Rise completing the last 30/100 period, then drop enable mid high phase
    q_hi.push_back(32'd30);
    q_per.push_back(32'd100);
    armed = 0;
    ifa.pwmInput = 1'b1;
    repeat (10) tick();
    ifa.enable = 1'b0;
    repeat (10) tick();
    check("dis_hold_highTime", 32'(ifa.highTime), 32'd30);
    check("dis_hold_period", 32'(ifa.period), 32'd100);
    ifa.pwmInput = 1'b0;
    repeat (70) tick();
    ifa.pwmInput = 1'b1;
    repeat (5) tick();
    ifa.enable = 1'b1;
    repeat (25) tick();
    ifa.pwmInput = 1'b0;
    repeat (70) tick();
    check("reen_hold_highTime", 32'(ifa.highTime), 32'd30);
    check("reen_hold_period", 32'(ifa.period), 32'd100);
    repeat (3) pwm_period(30, 70);

    // Reset pulse during the low phase
    pwm_period(30, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    armed = 0;
    @(negedge clk);
    check("midrst_highTime", 32'(ifa.highTime), 32'd0);
    check("midrst_period", 32'(ifa.period), 32'd0);
    check("midrst_valid", 32'(ifa.valid), 32'd0);
    check("midrst_overflow", 32'(ifa.overflow), 32'd0);
    #1;
    repeat (50) tick();
    repeat (3) pwm_period(30, 70);

    for (int i = 0; i < 20 && q_hi.size() != 0; i++) tick();
    check("scoreboard_drained", 32'(q_hi.size()), 32'd0);

    // 8-bit saturation: rise at edge+3 loads cnt=1, cnt=255 after 257 edges
    ifb.enable = 1'b1;
    repeat (5) tick();
    ifb.pwmInput = 1'b1;
    repeat (257) tick();
    check("sat_before", 32'(ifb.overflow), 32'd0);
    tick();
    check("sat_set", 32'(ifb.overflow), 32'd1);
    ifb.clearOverflow = 1'b1;
    tick();
    ifb.clearOverflow = 1'b0;
    check("sat_cleared", 32'(ifb.overflow), 32'd0);

    ifb.pwmInput = 1'b0;
    repeat (5) tick();
    ifb.pwmInput = 1'b1;
    repeat (257) tick();
    check("sat2_before", 32'(ifb.overflow), 32'd0);
    ifb.clearOverflow = 1'b1;
    tick();
    ifb.clearOverflow = 1'b0;
    check("sat2_set_wins", 32'(ifb.overflow), 32'd1);
    check("sat_no_valid", 32'(valid8_cnt), 32'd0);
    check("sat_highTime", 32'(ifb.highTime), 32'd0);
    check("sat_period", 32'(ifb.period), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform: high time and period in `clk` cycles. It is the receive-side counterpart of the SoC PWM generator. It is used in loop-back benches against `pwmOutput` and as a standalone capture peripheral. Results are latched per complete period and flagged with a one-cycle `valid` pulse. Counter saturation is reported through a sticky overflow flag.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: width of the internal counter and of `highTime`/`period`.
- `SYNC_STAGES`, default 2: flip-flops in the input synchronizer, minimum 2.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  capture enable.
- `pwmInput`  in  1  asynchronous PWM input.
- `clearOverflow`  in  1  one-cycle pulse that clears `overflow`.
- `highTime`  out  CNT_WIDTH  high-phase length of the last complete period, in cycles.
- `period`  out  CNT_WIDTH  length of the last complete period, rise to rise, in cycles.
- `valid`  out  1  one-cycle pulse when `highTime`/`period` update.
- `overflow`  out  1  sticky: the counter saturated during a measurement.

## Operation
- Input path:
  - `pwmInput` passes through a SYNC_STAGES synchronizer, giving `s`, plus one delay register, giving `s_d`.
  - rise = `s & ~s_d`; fall = `~s & s_d`.
- Counter `cnt` (CNT_WIDTH bits):
  - loads 1 on a rise detected in WAIT_RISE or MEAS_LOW.
  - otherwise increments in MEAS_HIGH/MEAS_LOW.
  - holds 0 in IDLE/WAIT_RISE.
- States:
  - IDLE: entered on reset or `enable`=0. `cnt`=0. Goes to WAIT_RISE when `enable`=1.
  - WAIT_RISE: on rise, goes to MEAS_HIGH. A partial high phase present at enable time is ignored.
  - MEAS_HIGH: on fall, captures `hi_cap`←`cnt` (internal) and goes to MEAS_LOW.
  - MEAS_LOW: on rise, sets `highTime`←`hi_cap`, `period`←`cnt`, pulses `valid`, and goes to MEAS_HIGH with `cnt`←1. Back-to-back periods are measured with no gap.
- Saturation:
  - If `cnt` equals all-ones in MEAS_HIGH/MEAS_LOW and no edge is detected that cycle, `overflow`←1.
  - The state returns to WAIT_RISE; no `valid` is produced.
  - A constant 0% or 100% input therefore yields `overflow` and never yields `valid`.
- `enable`=0 in any state forces IDLE on the next edge:
  - the measurement in progress is discarded.
  - `highTime`/`period`/`overflow` hold their values.
- `clearOverflow`: clears `overflow`. If a new saturation occurs in the same cycle, the set wins.
- Reset: all outputs 0, state IDLE, synchronizer flops 0, `hi_cap` 0.
- Widths: measured values are exact modulo the saturation rule. Maximum reportable value is 2^CNT_WIDTH−1.

## Timing
- Input-to-detection latency is SYNC_STAGES+1 cycles from the first `clk` edge sampling the new level.
  - The latency is identical for rises and falls, so the measured values carry no offset.
- `valid` is high for exactly one cycle: the cycle after the terminating rise is detected.
  - `highTime`/`period` change on the same edge that raises `valid`.
- A high phase of H sampled cycles reports `highTime`=H. A period of P sampled cycles reports `period`=P.
- Minimum measurable waveform: H=1, P=2. The input toggles every cycle and must pass the synchronizer intact.
- First `valid` after enable or reset arrives after the second detected rise, never earlier.
- Output registers hold between `valid` pulses. Consumers may sample at any time.

## Test plan
- Bench: 10 ns clock, `rst`=1 for 2 cycles then 0.
- Steady PWM, `enable`=1, high 30 / low 70 cycles → first `valid` after the second rise with `highTime`=30, `period`=100. `valid` repeats every 100 cycles with identical values; `overflow`=0.
- Duty change at a rising edge to high 75 / low 25 → the next `valid` reports `highTime`=75, `period`=100. No intermediate or corrupted values appear.
- CNT_WIDTH=8, `pwmInput` held at 1 after one rise → `overflow`=1 once `cnt` reaches 255; `valid` never pulses.
  - Pulse `clearOverflow` → `overflow`=0.
  - Pulse `clearOverflow` in the same cycle as a fresh saturation → `overflow` stays 1.
- Toggle `pwmInput` every cycle (H=1, P=2) → `valid` every 2 cycles with `highTime`=1, `period`=2.
- Drop `enable` mid high phase after a previous `valid` of 30/100 → outputs hold 30/100 and no `valid` occurs.
  - Re-enable mid high phase → the partial phase is ignored; the next `valid` comes after two full rises and reports 30/100.
- Assert `rst` for one cycle mid-MEAS_LOW → the next cycle `highTime`=`period`=0 and `valid`=`overflow`=0.
  - After `rst` falls, the first `valid` comes only after two rises.
